// File: rtl/bf_uart_pkg.sv
// bf_uart_pkg: shared FSM state type and frame constants for bf_uart_tx.
// Frame length follows BF_UART_TX_PARITY_EN (8E1 when defined, 8N1 otherwise).
package bf_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int DATA_BITS = 8;
  function automatic int frame_bits();
`ifdef BF_UART_TX_PARITY_EN
    return 11;
`else
    return 10;
`endif
  endfunction
endpackage

// File: rtl/bf_byte_fifo.sv
// bf_byte_fifo: byte FIFO with combinational head; full/empty derived from count.
module bf_byte_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic [FIFO_DEPTH_LOG2:0] count,
  output logic                     full,
  output logic                     empty
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  logic [7:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] rd_q, wr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q;
  logic                       do_push;
  assign empty    = count_q == '0;
  assign full     = count_q[FIFO_DEPTH_LOG2];
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign do_push  = reset && push && (!full || pop);
  assign pop_data = mem_q[rd_q];
  assign count    = count_q;
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + {{FIFO_DEPTH_LOG2{1'b0}}, do_push} - {{FIFO_DEPTH_LOG2{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/bf_uart_tx.sv
// bf_uart_tx: buffers BF core output bytes and serialises them as UART on tx.
// Define BF_UART_TX_PARITY_EN for an even-parity bit (8E1); default is 8N1.
module bf_uart_tx
  import bf_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 16,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               out_val,
  input  logic                     out_enable,
  output logic                     tx,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     overflow
);
  localparam int BW = $clog2(CLKS_PER_BIT);
`ifdef BF_UART_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = PARITY;
  logic par_q;
`else
  localparam tx_state_t AFTER_DATA = STOP;
`endif
  tx_state_t   state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q, head;
  logic        tx_q, ovf_q, full, empty, last, pop;
  bf_byte_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (out_enable),
    .push_data (out_val),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );
  assign last     = baud_q == BW'(CLKS_PER_BIT - 1);
  // Popping at the last STOP cycle chains frames with no idle gap.
  assign pop      = !empty && (state_q == IDLE || (state_q == STOP && last));
  assign busy     = state_q != IDLE || !empty;
  assign tx       = tx_q;
  assign overflow = ovf_q;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef BF_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
`ifdef BF_UART_TX_PARITY_EN
      tx_q <= state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : state_q == PARITY ? par_q : 1'b1;
`else
      tx_q <= state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
`endif
      if (out_enable && full && !pop) ovf_q <= 1'b1;
      baud_q <= (state_q == IDLE || last) ? '0 : baud_q + 1'b1;
      if (pop) begin
        state_q <= START;
        shift_q <= head;
        bit_q   <= '0;
`ifdef BF_UART_TX_PARITY_EN
        par_q   <= ^head;
`endif
      end else if (last && state_q != IDLE) begin
        state_q <= state_q == START ? DATA :
                   state_q == DATA ? (bit_q == 3'(DATA_BITS - 1) ? AFTER_DATA : DATA) :
                   state_q == PARITY ? STOP : IDLE;
        if (state_q == DATA) begin
          shift_q <= shift_q >> 1;
          bit_q   <= bit_q + 1'b1;
        end
      end
    end
  end
endmodule
